// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the multi-channel PWM block.
//   PWM_WIDTH, PWM_CHANNELS : default resolution and channel count
//   CH_R, CH_G, CH_B        : channel indices used by the colour mixer
//   pack_duty()             : builds the flat duty_in vector from R/G/B duties
package pwm_pkg;

  localparam int PWM_WIDTH    = 8;
  localparam int PWM_CHANNELS = 3;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Channel i occupies bits [i*PWM_WIDTH +: PWM_WIDTH] of duty_in.
  function automatic logic [PWM_CHANNELS*PWM_WIDTH-1:0] pack_duty(
    input logic [PWM_WIDTH-1:0] r,
    input logic [PWM_WIDTH-1:0] g,
    input logic [PWM_WIDTH-1:0] b
  );
    logic [PWM_CHANNELS*PWM_WIDTH-1:0] v;
    v = '0;
    v[CH_R*PWM_WIDTH +: PWM_WIDTH] = r;
    v[CH_G*PWM_WIDTH +: PWM_WIDTH] = g;
    v[CH_B*PWM_WIDTH +: PWM_WIDTH] = b;
    return v;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk down to the period-counter tick rate.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : run enable; while low the divider is held at 0
//   tick : high for one clk every PRESCALE enabled cycles
//          (every enabled cycle when PRESCALE=1)
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // A 1-bit counter is kept even for PRESCALE=1 so the logic stays regular;
  // in that case it never leaves 0 and tick simply follows en.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign tick = en && (pre_cnt == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with double-buffered duty values.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   en           : run enable; low stops the counter and forces outputs low
//   duty_in      : new duties, channel i at [i*WIDTH +: WIDTH]
//   load         : one-cycle strobe capturing duty_in into the pending set
//   pending      : captured duties are waiting for the next period boundary
//   period_start : one-cycle pulse in the cycle after the counter wraps to 0
//   out          : registered PWM outputs, bit i = channel i
// Handshake: load is a fire-and-forget strobe with no ready; each cycle with
// load=1 overwrites the pending set, and the last write before a boundary wins.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = PWM_CHANNELS,
  parameter int WIDTH    = PWM_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic                      pending,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       out
);

  logic             tick;
  logic [WIDTH-1:0] count;
  logic             boundary;
  logic             pend_valid;
  logic             apply;
  logic [CHANNELS-1:0] hit;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // The wrap edge of the counter is the only point where duties may change
  // while running; while stopped there is no pulse to tear, so apply at once.
  assign boundary = tick && (count == {WIDTH{1'b1}});
  assign apply    = pend_valid && (boundary || !en);
  assign pending  = pend_valid;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  // A load in the apply cycle keeps pend_valid set: active takes the old
  // pending set while the new one is captured behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_valid <= 1'b1;
    end else if (apply) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] act_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_q <= '0;
        act_q  <= '0;
      end else begin
        if (load) begin
          pend_q <= duty_in[i*WIDTH +: WIDTH];
        end
        if (apply) begin
          act_q <= pend_q;
        end
      end
    end

    // Unsigned compare: duty k is high for counts 0..k-1.
    assign hit[i] = (count < act_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= en ? hit : '0;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: bench for pwm_multi (default 3x8-bit, PRESCALE=1) plus a
// second instance with WIDTH=4, PRESCALE=4 for the prescaler corner case.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam int P  = 1;
  localparam int PERIOD = (1 << W) * P;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              load = 1'b0;
  logic [CH*W-1:0]   duty = '0;
  logic              pending;
  logic              ps;
  logic [CH-1:0]     out;

  logic              en_p = 1'b0;
  logic              load_p = 1'b0;
  logic [11:0]       duty_p = '0;
  logic              pending_p;
  logic              ps_p;
  logic [2:0]        out_p;

  pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty),
    .load         (load),
    .pending      (pending),
    .period_start (ps),
    .out          (out)
  );

  pwm_multi #(.CHANNELS(3), .WIDTH(4), .PRESCALE(4)) dut_p (
    .clk          (clk),
    .rst          (rst),
    .en           (en_p),
    .duty_in      (duty_p),
    .load         (load_p),
    .pending      (pending_p),
    .period_start (ps_p),
    .out          (out_p)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter position derived from the number of enabled
  // cycles since the last stop, duties held as plain arrays.
  int         m_run = 0;
  logic [W-1:0] m_act[CH];
  logic [W-1:0] m_pnd[CH];
  logic       m_pv = 1'b0;
  logic [CH+1:0] exp_q[$];   // {pending, period_start, out}

  task automatic model_step();
    logic [CH-1:0] o;
    logic          p;
    int            cnt;
    logic          bnd;
    o = '0;
    p = 1'b0;
    if (rst) begin
      m_run = 0;
      m_pv  = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_act[i] = '0;
        m_pnd[i] = '0;
      end
    end else if (!en) begin
      m_run = 0;
      if (m_pv) begin
        for (int i = 0; i < CH; i++) m_act[i] = m_pnd[i];
        m_pv = 1'b0;
      end
      if (load) begin
        for (int i = 0; i < CH; i++) m_pnd[i] = duty[i*W +: W];
        m_pv = 1'b1;
      end
    end else begin
      cnt = (m_run / P) % (1 << W);
      for (int i = 0; i < CH; i++) o[i] = (cnt < int'(m_act[i]));
      bnd = ((m_run + 1) % PERIOD) == 0;
      p = bnd;
      if (bnd && m_pv) begin
        for (int i = 0; i < CH; i++) m_act[i] = m_pnd[i];
        m_pv = 1'b0;
      end
      if (load) begin
        for (int i = 0; i < CH; i++) m_pnd[i] = duty[i*W +: W];
        m_pv = 1'b1;
      end
      m_run++;
    end
    exp_q.push_back({m_pv, p, o});
  endtask

  // One clk: model sees the same inputs as the DUT, outputs compared #1 later.
  task automatic step();
    logic [CH+1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_out", int'(out), int'(e[CH-1:0]));
    chk("sb_period_start", int'(ps), int'(e[CH]));
    chk("sb_pending", int'(pending), int'(e[CH+1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [CH*W-1:0] v);
    duty = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!ps && n < 2 * PERIOD + 10);
    if (!ps) chk("wait_period_start_timeout", 0, 1);
  endtask

  // Called right after a period_start sample; runs one full period and
  // counts high cycles per channel. Optional loads at steps la1/la2 (0=none).
  task automatic measure(input int la1, input logic [CH*W-1:0] v1,
                         input int la2, input logic [CH*W-1:0] v2,
                         output int hr, output int hg, output int hb);
    int extra;
    hr = 0; hg = 0; hb = 0; extra = 0;
    for (int s = 1; s <= PERIOD; s++) begin
      if (s == la1) begin duty = v1; load = 1'b1; end
      if (s == la2) begin duty = v2; load = 1'b1; end
      step();
      load = 1'b0;
      if (la1 != 0 && s == la1 + 1 && la1 < PERIOD) chk("pending_after_load", int'(pending), 1);
      hr += int'(out[CH_R]);
      hg += int'(out[CH_G]);
      hb += int'(out[CH_B]);
      if (s < PERIOD && ps) extra++;
    end
    chk("period_start_mid", extra, 0);
    chk("period_start_end", int'(ps), 1);
  endtask

  typedef struct {
    logic [W-1:0] r, g, b;
    int           hr, hg, hb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int hr, hg, hb, n;

    for (int i = 0; i < CH; i++) begin
      m_act[i] = '0;
      m_pnd[i] = '0;
    end

    // ---- reset ----
    rst = 1'b1; en = 1'b1; load = 1'b1; duty = pack_duty(8'd9, 8'd9, 8'd9);
    repeat (3) step();
    chk("reset_out", int'(out), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_period_start", int'(ps), 0);
    load = 1'b0;
    rst = 1'b0;
    step();

    // ---- table-driven waveforms ----
    vecs[0] = '{r:8'd64,  g:8'd128, b:8'd0,  hr:64,  hg:128, hb:0};
    vecs[1] = '{r:8'd255, g:8'd1,   b:8'd17, hr:255, hg:1,   hb:17};
    vecs[2] = '{r:8'd0,   g:8'd0,   b:8'd0,  hr:0,   hg:0,   hb:0};
    vecs[3] = '{r:8'd200, g:8'd100, b:8'd2,  hr:200, hg:100, hb:2};
    vecs[4] = '{r:8'd64,  g:8'd128, b:8'd0,  hr:64,  hg:128, hb:0};
    for (int v = 0; v < 5; v++) begin
      do_load(pack_duty(vecs[v].r, vecs[v].g, vecs[v].b));
      wait_ps();
      measure(0, '0, 0, '0, hr, hg, hb);
      chk("vec_r", hr, vecs[v].hr);
      chk("vec_g", hg, vecs[v].hg);
      chk("vec_b", hb, vecs[v].hb);
    end

    // ---- shadow update: load R=200 at count 100, current pulse unchanged ----
    measure(100, pack_duty(8'd200, 8'd128, 8'd0), 0, '0, hr, hg, hb);
    chk("shadow_cur_r", hr, 64);
    chk("shadow_pending_clear", int'(pending), 0);
    measure(0, '0, 0, '0, hr, hg, hb);
    chk("shadow_next_r", hr, 200);

    // ---- boundary collision: pending R=10, then R=20 in the boundary cycle ----
    measure(10, pack_duty(8'd10, 8'd128, 8'd0), PERIOD,
            pack_duty(8'd20, 8'd128, 8'd0), hr, hg, hb);
    chk("coll_cur_r", hr, 200);
    chk("coll_pending_kept", int'(pending), 1);
    measure(0, '0, 0, '0, hr, hg, hb);
    chk("coll_next_r", hr, 10);
    chk("coll_pending_clear", int'(pending), 0);
    measure(0, '0, 0, '0, hr, hg, hb);
    chk("coll_after_r", hr, 20);

    // ---- two loads in one period: last wins ----
    measure(50, pack_duty(8'd30, 8'd128, 8'd0), 120,
            pack_duty(8'd40, 8'd128, 8'd0), hr, hg, hb);
    measure(0, '0, 0, '0, hr, hg, hb);
    chk("last_write_r", hr, 40);

    // ---- en=0 mid-period, immediate apply while stopped ----
    repeat (30) step();
    en = 1'b0;
    step();
    chk("stop_out", int'(out), 0);
    do_load(pack_duty(8'd255, 8'd0, 8'd1));
    step();
    chk("stop_applied_pending", int'(pending), 0);
    en = 1'b1;
    hr = 0; hg = 0; hb = 0;
    for (int s = 0; s < PERIOD; s++) begin
      step();
      if (s == 0) chk("restart_first_out_r", int'(out[CH_R]), 1);
      hr += int'(out[CH_R]);
      hg += int'(out[CH_G]);
      hb += int'(out[CH_B]);
    end
    chk("restart_r", hr, 255);
    chk("restart_g_zero", hg, 0);
    chk("restart_b", hb, 1);

    // ---- reset mid-operation with pend_valid=1 ----
    wait_ps();
    do_load(pack_duty(8'd90, 8'd90, 8'd90));
    repeat (76) step();
    rst = 1'b1;
    step();
    chk("midrst_out", int'(out), 0);
    chk("midrst_pending", int'(pending), 0);
    chk("midrst_period_start", int'(ps), 0);
    rst = 1'b0;
    n = 0;
    for (int s = 0; s < 300; s++) begin
      step();
      if (out != '0) n++;
    end
    chk("midrst_no_pulse", n, 0);

    // ---- prescaler instance: WIDTH=4, PRESCALE=4, duty 3 ----
    duty_p = {4'd3, 4'd3, 4'd3};
    load_p = 1'b1;
    step();
    load_p = 1'b0;
    step();
    en_p = 1'b1;
    n = 0;
    for (int s = 0; s < 64; s++) begin
      step();
      n += int'(out_p[0]);
    end
    chk("pre_high_clks", n, 12);
    n = 0;
    while (!ps_p && n < 200) begin step(); n++; end
    chk("pre_ps_seen", int'(ps_p), 1);
    n = 0;
    do begin step(); n++; end while (!ps_p && n < 200);
    chk("pre_ps_spacing", n, 64);
    en_p = 1'b0;

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) < 2) en = ~en;
      load = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < CH; i++) begin
        case ($urandom_range(0, 3))
          0: duty[i*W +: W] = '0;
          1: duty[i*W +: W] = '1;
          default: duty[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        endcase
      end
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator. It is the successor to the single-channel 8-bit PWM and drives the RGB LED channels of the colour mixer.
- One shared period counter, advanced by a programmable clock prescaler, feeds CHANNELS independent duty comparators.
- Duty values are double-buffered: a write lands in a pending register and becomes active only at a period boundary, so colour changes never produce torn or glitched pulses.
- All outputs are registered.

Parameters:
CHANNELS, 3, number of PWM outputs (1..16)
WIDTH, 8, duty and counter resolution in bits (2..16); period = 2^WIDTH ticks
PRESCALE, 1, clk cycles per counter tick (1..65536); 1 means tick every clk

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low means stopped and outputs low
duty_in  in  CHANNELS*WIDTH  new duty values; channel i is bits [i*WIDTH +: WIDTH]
load  in  1  single-cycle strobe; captures duty_in into the pending register
pending  out  1  high while captured values wait for the next period boundary
period_start  out  1  one-cycle pulse in the clk cycle after count wraps to 0
out  out  CHANNELS  PWM outputs; bit i belongs to channel i

Behaviour:
- Reset, checked on every posedge while rst=1:
  - pre_cnt=0, count=0.
  - active duty registers=0, pending duty registers=0, pend_valid=0.
  - out=0, period_start=0.
  - rst overrides en and load. Reset mid-period aborts the period immediately, with no partial pulse afterwards.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 while en=1.
  - tick=1 when pre_cnt==PRESCALE-1, and pre_cnt then wraps to 0.
  - PRESCALE=1 gives tick=1 on every en cycle. The pre_cnt width is $clog2(PRESCALE), minimum 1 bit.
- Period counter:
  - count is WIDTH bits and increments by 1 on each tick.
  - It wraps from 2^WIDTH-1 to 0. That wrap edge is the boundary (boundary = tick && count==2^WIDTH-1).
- Boundary actions:
  - If pend_valid, then active <= pending for all channels together and pend_valid <= 0.
  - period_start <= 1 for exactly one cycle, asserted whether or not an update occurred.
- Load rules:
  - On load=1, pending <= duty_in and pend_valid <= 1. A second load before the boundary overwrites pending; last write wins.
  - Load in the same cycle as the boundary: active takes the old pending value (if valid), pending takes the new duty_in, and pend_valid stays 1.
  - The pending port equals pend_valid.
- Compare:
  - Registered: out[i] <= en && (count < active[i]), evaluated on the current count, so there is one clk of latency from count to out.
  - duty=0 gives a constant low output.
  - duty=k gives k ticks high per period (k*PRESCALE clk cycles), starting at count=0.
  - Maximum duty is (2^WIDTH-1)/2^WIDTH. 100% is not representable; this is a deliberate choice.
- en=0:
  - pre_cnt and count are held at 0, out=0, period_start=0.
  - If pend_valid, active <= pending and pend_valid <= 0 on the next clk (immediate apply while stopped). load still captures.
- en rising:
  - The first tick occurs PRESCALE cycles later.
  - out rises in the first en=1 cycle (count=0) for every channel with active>0.
- Width rules:
  - All comparisons are unsigned.
  - duty_in is sliced per channel with no sign extension.
  - There is no arithmetic beyond the count and pre_cnt increments.

Decomposition:
- Package pwm_pkg holds:
  - default constants PWM_WIDTH=8, PWM_CHANNELS=3;
  - the channel index constants CH_R=0, CH_G=1, CH_B=2;
  - a function packing per-channel duty into the flat duty_in vector.
- Sub-module pwm_prescaler (parameter PRESCALE; ports clk, rst, en, tick) holds the tick generator.
- The top level holds count, the shadow registers and CHANNELS comparators, built in a generate loop.

Test Plan:
- Basic waveform (WIDTH=8, PRESCALE=1, CHANNELS=3): rst, then load duty {R=64, G=128, B=0} with en=1 → from the first full period, R high for exactly 64 of every 256 cycles, G high for 128, B constantly 0; period_start pulses every 256 cycles.
- Shadow update: mid-period (count=100) load R=200 → R's pulse in the current period still ends after 64 cycles; pending=1 until the wrap; the next period has R high for 200 cycles; pending returns to 0 together with the period_start pulse.
- Boundary collision:
  - Setup: pending R=10, then load R=20 in the exact boundary cycle.
  - Next period: R high for 10 cycles, pending=1.
  - Period after that: R high for 20 cycles.
  - Also check that two loads within one period apply only the last value.
- Prescaler (PRESCALE=4, WIDTH=4): duty=3 → out high for 12 clk of every 64-clk period; period_start spacing is 64 clk.
- Enable/extremes:
  - en=0 mid-period → out=0 on the next clk, count=0.
  - Load duty=255 while stopped, then set en=1 → high for 255 of 256 cycles immediately, with no wait for a boundary.
  - duty=0 → out is never high.
- Reset mid-operation: assert rst at count=77 with pend_valid=1 → every output, count and pending read 0 on the next clk; after release, out stays 0 until a new load.
